// File: rtl/wb_stream_wr_pkg.sv
// Shared definitions for the Wishbone write streamer: FSM state encodings
// and skid-buffer sizing.
package wb_stream_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam logic [1:0]  SKID_FULL  = 2'(SKID_DEPTH);
  localparam logic [1:0]  OUTST_MAX  = 2'd2;

endpackage

// File: rtl/wb_stream_wr_skid.sv
// wb_skid2: 2-entry FIFO between slave acceptance and master issue.
// Entry 0 is always the head; a pop shifts entry 1 down.
module wb_skid2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);
  import wb_stream_wr_pkg::*;

  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != SKID_FULL) || do_pop);
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = dat_i;
        else               e1_d = dat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop: count unchanged, new word lands behind the survivor.
        if (cnt_q == 2'd1) begin
          e0_d = dat_i;
        end else begin
          e0_d = e1_q;
          e1_d = dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/wb_stream_wr.sv
// Wishbone stream writer: buffers slave words and writes them to sequential
// addresses on a pipelined master port. Frame mode: WB_STREAM_WR_FRAME_EN.
module wb_stream_wr
  import wb_stream_wr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WBITS = 10,
  parameter int unsigned WORDS = 1 << WBITS,
  parameter int unsigned START = 0,
  parameter int unsigned LAST  = START + WORDS - 1,
  parameter int unsigned STEP  = 1,
  parameter int unsigned DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_cyc_i,
  input  logic             s_stb_i,
  input  logic             s_we_i,
  output logic             s_ack_o,
  output logic             s_wat_o,
  input  logic [WIDTH-1:0] s_dat_i,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  input  logic             m_ack_i,
  input  logic             m_wat_i,
  output logic [WBITS-1:0] m_adr_o,
  output logic [WIDTH-1:0] m_dat_o,
  input  logic             clr_i,
  output logic             done_o
);

  localparam logic [WBITS-1:0] START_A = WBITS'(START);
  localparam logic [WBITS-1:0] LAST_A  = WBITS'(LAST);
  localparam logic [WBITS-1:0] STEP_A  = WBITS'(STEP);

  // DELAY only shaped simulation-time NBA delays in the original source.
  if (DELAY != 0) begin : g_sim_delay
  end

  state_e           state_q, state_d;
  logic [WBITS-1:0] adr_q, adr_d;
  logic [1:0]       outst_q, outst_d;
  logic             ack_q;
  logic [1:0]       count;
  logic [WIDTH-1:0] head;
  logic             accept, issue, ack_v, frame_done;

  wb_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (accept),
    .pop_i  (issue),
    .dat_i  (s_dat_i),
    .head_o (head),
    .count_o(count)
  );

  always_comb begin
    state_d = state_q;
    m_cyc_o = (state_q != ST_IDLE);
    s_wat_o = (count == SKID_FULL) || frame_done;
    m_stb_o = (count != 2'd0) && (state_q != ST_IDLE) && !frame_done;
    accept  = s_cyc_i && s_stb_i && s_we_i && !s_wat_o;
    issue   = m_stb_o && !m_wat_i;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_BUSY;
      ST_BUSY:  if (!s_cyc_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (s_cyc_i)                                  state_d = ST_BUSY;
        else if ((count == 2'd0) && (outst_q == 2'd0)) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_v   = m_ack_i && (outst_q != 2'd0);
    outst_d = outst_q;
    unique case ({issue, ack_v})
      2'b10:   if (outst_q != OUTST_MAX) outst_d = outst_q + 2'd1;
      2'b01:   outst_d = outst_q - 2'd1;
      default: ;
    endcase
    adr_d = adr_q;
    if (clr_i)      adr_d = START_A;
    else if (issue) adr_d = (adr_q == LAST_A) ? START_A : adr_q + STEP_A;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      adr_q   <= START_A;
      outst_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      outst_q <= outst_d;
      ack_q   <= accept;
    end
  end

`ifdef WB_STREAM_WR_FRAME_EN
  logic done_q;

  // Issue at LAST ends the frame; clr_i reopens it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         done_q <= 1'b0;
    else if (clr_i)                      done_q <= 1'b0;
    else if (issue && (adr_q == LAST_A)) done_q <= 1'b1;
  end

  assign frame_done = done_q;
`else
  assign frame_done = 1'b0;
`endif

  assign s_ack_o = ack_q;
  assign m_we_o  = 1'b1;
  assign m_adr_o = adr_q;
  assign m_dat_o = head;
  assign done_o  = frame_done;

endmodule

// File: tb/tb_wb_stream_wr.sv
// Randomized self-checking bench for wb_stream_wr (WBITS=3 so wraps occur),
// against a queue-based transaction model; frame behaviour follows the macro.
module tb_wb_stream_wr;

  localparam int unsigned W  = 8;
  localparam int unsigned AB = 3;
  localparam logic [AB-1:0] ST_ADR = 3'd0;
  localparam logic [AB-1:0] LS_ADR = 3'd7;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          s_cyc_i, s_stb_i, s_we_i, s_ack_o, s_wat_o;
  logic [W-1:0]  s_dat_i;
  logic          m_cyc_o, m_stb_o, m_we_o, m_ack_i, m_wat_i;
  logic [AB-1:0] m_adr_o;
  logic [W-1:0]  m_dat_o;
  logic          clr_i, done_o;

  wb_stream_wr #(.WIDTH(W), .WBITS(AB), .START(0)) dut (
    .clk_i  (clk_i),   .rst_ni (rst_ni),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i (s_we_i),
    .s_ack_o(s_ack_o), .s_wat_o(s_wat_o), .s_dat_i(s_dat_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o (m_we_o),
    .m_ack_i(m_ack_i), .m_wat_i(m_wat_i), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .clr_i  (clr_i),   .done_o (done_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: words accepted but not yet written, next write address, frame flag,
  // expected slave ack, device ack owed next cycle, writes not yet acked.
  logic [W-1:0]  q[$];
  logic [AB-1:0] adr;
  bit            done_m, ack_exp, ack_pend;
  int            outst;
  logic [W-1:0]  nw;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    adr      = ST_ADR;
    done_m   = 1'b0;
    ack_exp  = 1'b0;
    ack_pend = 1'b0;
    outst    = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc"}, m_cyc_o, 0);
    chk({tag, "_stb"}, m_stb_o, 0);
    chk({tag, "_ack"}, s_ack_o, 0);
    chk({tag, "_wat"}, s_wat_o, 0);
    chk({tag, "_adr"}, m_adr_o, ST_ADR);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_we"}, m_we_o, 1);
  endtask

  // One cycle: check outputs at negedge, drive inputs, advance model to next edge.
  task automatic step(input bit cyc, input bit stb, input bit we, input bit wat, input bit clr);
    bit wat_e, stb_e, acc, iss;
    wat_e = (q.size() == 2) || done_m;
    stb_e = (q.size() != 0) && !done_m;
    chk("s_ack", s_ack_o, ack_exp);
    chk("s_wat", s_wat_o, wat_e);
    chk("m_stb", m_stb_o, stb_e);
    chk("done", done_o, done_m);
    if (q.size() != 0 || outst != 0) chk("m_cyc", m_cyc_o, 1);
    if (stb_e) begin
      chk("m_adr", m_adr_o, adr);
      chk("m_dat", m_dat_o, q[0]);
    end
    s_cyc_i = cyc; s_stb_i = stb; s_we_i = we; s_dat_i = nw;
    m_wat_i = wat; m_ack_i = ack_pend; clr_i = clr;
    acc = cyc && stb && we && !wat_e;
    iss = stb_e && !wat;
    if (iss) void'(q.pop_front());
    if (acc) begin
      q.push_back(nw);
      nw = nw + 8'd1;
    end
`ifdef WB_STREAM_WR_FRAME_EN
    if (clr)                        done_m = 1'b0;
    else if (iss && adr == LS_ADR)  done_m = 1'b1;
`endif
    if (clr)      adr = ST_ADR;
    else if (iss) adr = (adr == LS_ADR) ? ST_ADR : adr + 3'd1;
    outst    = outst + (iss ? 1 : 0) - ((ack_pend && outst > 0) ? 1 : 0);
    ack_pend = iss;
    ack_exp  = acc;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0;
    s_cyc_i = 0; s_stb_i = 0; s_we_i = 0; s_dat_i = '0;
    m_ack_i = 0; m_wat_i = 0; clr_i = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk_reset_outputs("rst");
    rst_ni = 1'b1;

    nw = 8'h11;
    repeat (4) step(1, 1, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0);
    chk("drain_idle", m_cyc_o, 0);

    repeat (5) step(1, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    chk("we0_idle", m_cyc_o, 0);
    chk("we0_adr", m_adr_o, adr);

    repeat (6) step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 0);

    nw = 8'h40;
    repeat (2) step(1, 1, 1, 0, 0);
    repeat (5) step(1, 1, 1, 1, 0);
    repeat (4) step(1, 1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);

    nw = 8'h80;
    repeat (3) step(1, 1, 1, 1, 0);
    chk("pre_rst_full", s_wat_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    s_cyc_i = 0; s_stb_i = 0; s_we_i = 0; m_ack_i = 0; m_wat_i = 0; clr_i = 0;
    model_reset();
    @(negedge clk_i);
    chk("rst_hold_stb", m_stb_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    nw = 8'hA0;
    repeat (3) step(1, 1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0);
    end

    step(0, 0, 0, 0, 1);
    repeat (8) step(0, 0, 0, 0, 0);
    chk("final_idle", m_cyc_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
